// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// result laid out as {remainder, quotient} for a direct load into Z.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic                 sop_r;
  logic                 qneg_r;
  logic                 rneg_r;
  logic [WIDTH-1:0]     quo_r;
  logic [WIDTH-1:0]     rem_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 dbz_r;
  logic [2*WIDTH-1:0]   result_r;

  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     dvs_s;
  logic [WIDTH:0]       shift_s;
  logic [WIDTH:0]       diff_s;
  logic [WIDTH-1:0]     rem_next_s;
  logic [WIDTH-1:0]     quo_next_s;
  logic [WIDTH-1:0]     qfix_s;
  logic [WIDTH-1:0]     rfix_s;

  // Operand magnitudes, one restoring step, and final sign correction.
  always_comb begin
    a_mag_s    = dividend;
    dvs_s      = b_r;
    rem_next_s = rem_r;
    quo_next_s = quo_r;
    qfix_s     = quo_r;
    rfix_s     = rem_r;
    if (signed_op && dividend[WIDTH-1]) begin
      a_mag_s = -dividend;
    end else begin
      a_mag_s = dividend;
    end
    if (sop_r && b_r[WIDTH-1]) begin
      dvs_s = -b_r;
    end else begin
      dvs_s = b_r;
    end
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvs_s};
    // A borrow out of the top bit means the trial subtraction went negative: restore.
    if (diff_s[WIDTH]) begin
      rem_next_s = shift_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_next_s = diff_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end
    if (qneg_r) begin
      qfix_s = -quo_r;
    end else begin
      qfix_s = quo_r;
    end
    if (rneg_r) begin
      rfix_s = -rem_r;
    end else begin
      rfix_s = rem_r;
    end
  end

  // Control FSM with registered status and result.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r  <= IDLE;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      sop_r    <= 1'b0;
      qneg_r   <= 1'b0;
      rneg_r   <= 1'b0;
      quo_r    <= ZERO_W;
      rem_r    <= ZERO_W;
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      result_r <= {ZERO_W, ZERO_W};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r    <= dividend;
            b_r    <= divisor;
            sop_r  <= signed_op;
            qneg_r <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_r <= signed_op & dividend[WIDTH-1];
            quo_r  <= a_mag_s;
            rem_r  <= ZERO_W;
            cnt_r  <= CNT_ZERO;
            dbz_r  <= 1'b0;
            if (divisor == ZERO_W) begin
              state_r <= DONE;
            end else begin
              state_r <= RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        RUN: begin
          quo_r <= quo_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          result_r <= {rfix_s, qfix_s};
          busy_r   <= 1'b0;
          state_r  <= DONE;
        end
        DONE: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
          // Divide by zero skipped RUN/FIX, so its result is produced here.
          if (b_r == ZERO_W) begin
            dbz_r    <= 1'b1;
            result_r <= {a_r, ONES_W};
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign result      = result_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors plus random operations
// compared against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           clear;
  logic           start;
  logic           signed_op;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .result(result)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
      end
    end
  end

  // Reference: plain integer division; SV integer division truncates toward zero.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == 0) return {a, {W{1'b1}}};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2*W-1:0] res, output int lat, output logic dbz,
                        output logic dbz_after_start, output logic busy_seen,
                        output logic timeout);
    @(negedge clock);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; signed_op = ~s;
    dbz_after_start = div_by_zero;
    busy_seen = busy;
    lat = 0; timeout = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (done) begin lat = i; timeout = 1'b0; break; end
      busy_seen |= busy;
    end
    res = result;
    dbz = div_by_zero;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %0b want 0", div_by_zero); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge clock);
    clear = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] res; int lat; logic dbz, dbz0, bs, to;
    run_op(32'd100, 32'd7, 1'b0, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL unsigned_timeout: no done within 100 cycles"); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL unsigned_latency: got %0d want 34", lat); end
    n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL unsigned_result: got %h want %h", res, {32'd2, 32'd14}); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL unsigned_dbz: got %0b want 0", dbz); end
    n_checks++; if (bs !== 1'b1) begin n_fail++; $display("FAIL unsigned_busy: got %0b want 1 during run", bs); end
  endtask

  task automatic test_signed();
    logic [2*W-1:0] res; int lat; logic dbz, dbz0, bs, to;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL signed_m7_2: got %h want %h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || res !== {32'd1, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL signed_7_m2: got %h want %h", res, {32'd1, 32'hFFFFFFFD}); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || res !== {32'd0, 32'h80000000}) begin n_fail++; $display("FAIL signed_overflow: got %h want %h", res, {32'd0, 32'h80000000}); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL overflow_flag: got %0b want 0", dbz); end
  endtask

  task automatic test_div_by_zero();
    logic [2*W-1:0] res; int lat; logic dbz, dbz0, bs, to;
    run_op(32'h12345678, 32'd0, 1'b0, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || lat != 1) begin n_fail++; $display("FAIL dbz_latency: got %0d want 1 (timeout=%0b)", lat, to); end
    n_checks++; if (res !== {32'h12345678, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL dbz_result: got %h want %h", res, {32'h12345678, 32'hFFFFFFFF}); end
    n_checks++; if (dbz !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %0b want 1", dbz); end
    n_checks++; if (bs !== 1'b0) begin n_fail++; $display("FAIL dbz_busy: got %0b want 0", bs); end
    run_op(32'd9, 32'd4, 1'b0, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (dbz0 !== 1'b0) begin n_fail++; $display("FAIL dbz_clear_on_start: got %0b want 0", dbz0); end
    n_checks++; if (to || res !== {32'd1, 32'd2}) begin n_fail++; $display("FAIL after_dbz_result: got %h want %h", res, {32'd1, 32'd2}); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] res, exp; int lat; logic dbz, dbz0, bs, to;
    logic [W-1:0] a, b; logic s;
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 9);
        3: b = 32'hFFFFFFFF;
        default: b = ($urandom_range(0, 2) == 0) ? 32'd0 : a;
      endcase
      s = $urandom_range(0, 1);
      exp = model(a, b, s);
      run_op(a, b, s, res, lat, dbz, dbz0, bs, to);
      n_checks++; if (to || res !== exp) begin n_fail++; $display("FAIL random_result[%0d]: a=%h b=%h s=%0b got %h want %h", k, a, b, s, res, exp); end
      n_checks++; if (lat != ((b == 0) ? 1 : 34)) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", k, lat, (b == 0) ? 1 : 34); end
      n_checks++; if (dbz !== (b == 0)) begin n_fail++; $display("FAIL random_dbz[%0d]: got %0b want %0b", k, dbz, (b == 0)); end
    end
  endtask

  task automatic test_start_ignored();
    logic [2*W-1:0] prev, exp; int lat, dcount;
    prev = result;
    exp = model(32'd1000000, 32'd37, 1'b0);
    @(negedge clock);
    dividend = 32'd1000000; divisor = 32'd37; signed_op = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'd3;
    lat = 0; dcount = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 10) begin start = 1'b1; dividend = 32'd5; divisor = 32'd2; signed_op = 1'b1; end
      @(posedge clock); #1;
      start = 1'b0;
      if (i == 5) begin
        n_checks++; if (result !== prev) begin n_fail++; $display("FAIL result_hold_during_run: got %h want %h", result, prev); end
      end
      if (done) begin dcount++; if (lat == 0) lat = i; end
    end
    n_checks++; if (dcount != 1) begin n_fail++; $display("FAIL ignored_start_done_count: got %0d want 1", dcount); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL ignored_start_latency: got %0d want 34", lat); end
    n_checks++; if (result !== exp) begin n_fail++; $display("FAIL ignored_start_result: got %h want %h", result, exp); end
  endtask

  task automatic test_clear();
    logic [2*W-1:0] res; int lat, dcount; logic dbz, dbz0, bs, to;
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_done: got %0b want 0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL clear_dbz: got %0b want 0", div_by_zero); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL clear_result: got %h want 0", result); end
    dcount = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dcount++; end
    n_checks++; if (dcount != 0) begin n_fail++; $display("FAIL clear_no_done: got %0d pulses want 0", dcount); end
    // clear and start together: clear wins
    @(negedge clock);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; clear = 1'b0;
    dcount = 0;
    repeat (40) begin @(posedge clock); #1; if (done || busy) dcount++; end
    n_checks++; if (dcount != 0) begin n_fail++; $display("FAIL clear_priority: got %0d active cycles want 0", dcount); end
    run_op(32'd100, 32'd7, 1'b0, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || lat != 34 || res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL after_clear_op: got %h lat %0d want %h lat 34", res, lat, {32'd2, 32'd14}); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] res; int lat; logic dbz, dbz0, bs, to;
    run_op(32'hFFFFFF9C, 32'd10, 1'b1, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || res !== {32'd0, 32'hFFFFFFF6}) begin n_fail++; $display("FAIL b2b_first: got %h want %h", res, {32'd0, 32'hFFFFFFF6}); end
    run_op(32'hFFFFFF9C, 32'd10, 1'b0, res, lat, dbz, dbz0, bs, to);
    n_checks++; if (to || lat != 34 || res !== model(32'hFFFFFF9C, 32'd10, 1'b0)) begin n_fail++; $display("FAIL b2b_second: got %h lat %0d want %h lat 34", res, lat, model(32'hFFFFFF9C, 32'd10, 1'b0)); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_start_ignored();
    test_random();
    test_back_to_back();
    test_clear();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
